// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the execution sequencer: mode encodings and default widths.
// The mode encoding is also the value driven on the modo output.
package controle_execucao_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 24;

  typedef enum logic [1:0] {
    ST_STEP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALTED  = 2'd3
  } modo_t;

  // Flips between the two user-selectable modes (STEP <-> RUN)
  function automatic modo_t alterna_modo(input modo_t m);
    return (m == ST_RUN) ? ST_STEP : ST_RUN;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for an already-debounced button level.
// The history register resets to 1 so a button held through reset release gives no edge.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/controle_execucao.sv
// Execution sequencer: turns button edges into the core clock-enable and serves IN
// requests by latching the board switches with a one-cycle ack pulse.
module controle_execucao
  import controle_execucao_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RUN_DIV    = 1,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic                  btn_modo,
  input  logic                  btn_confirma,
  input  logic [DATA_WIDTH-1:0] chaves,
  input  logic                  in_req,
  input  logic                  halt,
  output logic                  cpu_en,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic [1:0]            modo,
  output logic                  aguardando
);

  localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(RUN_DIV - 1);

  modo_t                 state, state_next;
  modo_t                 ret_mode, ret_next;
  logic [CNT_WIDTH-1:0]  div_cnt, div_next;
  logic                  cpu_en_next, in_ack_next;
  logic [DATA_WIDTH-1:0] in_data_next;
  logic                  rise_step, rise_modo, rise_confirma;
  logic                  run_tick;

  detector_borda u_borda_step (
    .clock (clock),
    .reset (reset),
    .btn   (btn_step),
    .rise  (rise_step)
  );

  detector_borda u_borda_modo (
    .clock (clock),
    .reset (reset),
    .btn   (btn_modo),
    .rise  (rise_modo)
  );

  detector_borda u_borda_confirma (
    .clock (clock),
    .reset (reset),
    .btn   (btn_confirma),
    .rise  (rise_confirma)
  );

  assign run_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_STEP;
      ret_mode   <= ST_STEP;
      div_cnt    <= '0;
      cpu_en     <= 1'b0;
      in_ack     <= 1'b0;
      in_data    <= '0;
      aguardando <= 1'b0;
    end else begin
      state      <= state_next;
      ret_mode   <= ret_next;
      div_cnt    <= div_next;
      cpu_en     <= cpu_en_next;
      in_ack     <= in_ack_next;
      in_data    <= in_data_next;
      aguardando <= (state_next == ST_WAIT_IN);
    end
  end

  // Priority: halt, then in_req, then button edges
  always_comb begin
    state_next = state;
    ret_next   = ret_mode;
    div_next   = div_cnt;
    if (halt) begin
      state_next = ST_HALTED;
    end else begin
      case (state)
        ST_STEP, ST_RUN: begin
          if (in_req) begin
            ret_next   = state;
            state_next = ST_WAIT_IN;
          end else if (rise_modo) begin
            state_next = alterna_modo(state);
            div_next   = '0;
          end else if (state == ST_RUN) begin
            div_next = run_tick ? '0 : div_cnt + 1'b1;
          end
        end
        ST_WAIT_IN: begin
          if (!in_req || rise_confirma) begin
            state_next = ret_mode;
            div_next   = '0;
          end else if (rise_modo) begin
            ret_next = alterna_modo(ret_mode);
          end
        end
        default: ;
      endcase
    end
  end

  // A mode change or a pending IN request suppresses any new cpu_en pulse
  always_comb begin
    cpu_en_next  = 1'b0;
    in_ack_next  = 1'b0;
    in_data_next = in_data;
    if (!halt) begin
      case (state)
        ST_STEP: cpu_en_next = rise_step & ~rise_modo & ~in_req;
        ST_RUN:  cpu_en_next = run_tick & ~rise_modo & ~in_req;
        ST_WAIT_IN: begin
          if (in_req && rise_confirma) begin
            in_ack_next  = 1'b1;
            in_data_next = chaves;
          end
        end
        default: ;
      endcase
    end
  end

  assign modo = state;

endmodule

// File: tb/tb_controle_execucao.sv
// Self-checking bench for controle_execucao: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural model of the sequencer.
module tb_controle_execucao;

  localparam int DW = 16;
  localparam int RD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          btn_step = 1'b0, btn_modo = 1'b0, btn_confirma = 1'b0;
  logic [DW-1:0] chaves = '0;
  logic          in_req = 1'b0, halt = 1'b0;
  logic          cpu_en, in_ack, aguardando;
  logic [DW-1:0] in_data;
  logic [1:0]    modo;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Model: modes as plain integers 0 STEP, 1 RUN, 2 WAIT_IN, 3 HALTED
  int            mMode, mRet, mRunCount;
  logic          mEn, mAck;
  logic [DW-1:0] mData;
  logic          pStep, pModo, pConf;

  controle_execucao #(.DATA_WIDTH(DW), .RUN_DIV(RD), .CNT_WIDTH(24)) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_step     (btn_step),
    .btn_modo     (btn_modo),
    .btn_confirma (btn_confirma),
    .chaves       (chaves),
    .in_req       (in_req),
    .halt         (halt),
    .cpu_en       (cpu_en),
    .in_ack       (in_ack),
    .in_data      (in_data),
    .modo         (modo),
    .aguardando   (aguardando)
  );

  always #5 clock = ~clock;

  task modelReset();
    mMode = 0; mRet = 0; mRunCount = 0;
    mEn = 1'b0; mAck = 1'b0; mData = '0;
    pStep = 1'b1; pModo = 1'b1; pConf = 1'b1;
  endtask

  // Advances the model by one clock using the inputs currently driven
  task modelCycle();
    logic rs, rm, rc, nEn, nAck;
    rs = btn_step & ~pStep;
    rm = btn_modo & ~pModo;
    rc = btn_confirma & ~pConf;
    nEn = 1'b0;
    nAck = 1'b0;
    if (halt) begin
      mMode = 3;
    end else if (mMode == 3) begin
      mMode = 3;
    end else if (mMode == 2) begin
      if (!in_req) begin
        mMode = mRet; mRunCount = 0;
      end else if (rc) begin
        mData = chaves; nAck = 1'b1; mMode = mRet; mRunCount = 0;
      end else if (rm) begin
        mRet = 1 - mRet;
      end
    end else if (in_req) begin
      mRet = mMode; mMode = 2;
    end else if (mMode == 0) begin
      if (rm) begin mMode = 1; mRunCount = 0; end
      else if (rs) nEn = 1'b1;
    end else begin
      if (rm) begin
        mMode = 0; mRunCount = 0;
      end else begin
        nEn = ((mRunCount % RD) == RD - 1);
        mRunCount++;
      end
    end
    mEn = nEn;
    mAck = nAck;
    pStep = btn_step; pModo = btn_modo; pConf = btn_confirma;
  endtask

  task checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task checkOutput();
    checkOne("cpu_en", 32'(cpu_en), 32'(mEn));
    checkOne("in_ack", 32'(in_ack), 32'(mAck));
    checkOne("in_data", 32'(in_data), 32'(mData));
    checkOne("modo", 32'(modo), 32'(mMode));
    checkOne("aguardando", 32'(aguardando), 32'(mMode == 2));
    checkOne("en_ack_excl", 32'(cpu_en & in_ack), 32'd0);
  endtask

  task applyStimulus(input logic s, input logic m, input logic c, input logic r,
                     input logic h, input logic [DW-1:0] sw);
    btn_step = s; btn_modo = m; btn_confirma = c;
    in_req = r; halt = h; chaves = sw;
    modelCycle();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    int enCount;
    logic reqLvl;

    // Reset with step held: no pulse after release
    btn_step = 1'b1;
    modelReset();
    #12;
    checkOutput();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) applyStimulus(1, 0, 0, 0, 0, '0);
    checkOne("held_step_no_pulse", 32'(cpu_en), 32'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOne("step_pulse", 32'(cpu_en), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOne("step_pulse_end", 32'(cpu_en), 32'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, '0);

    // RUN with divide-by-4
    applyStimulus(0, 1, 0, 0, 0, '0);
    checkOne("enter_run", 32'(modo), 32'd1);
    enCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 0, '0);
      if (cpu_en) enCount++;
    end
    checkOne("run_pulse_count", 32'(enCount), 32'd3);
    applyStimulus(0, 1, 0, 0, 0, '0);
    checkOne("leave_run_modo", 32'(modo), 32'd0);
    checkOne("leave_run_en", 32'(cpu_en), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // IN request from RUN, confirmed
    applyStimulus(0, 1, 0, 0, 0, '0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 16'hA5C3);
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 16'hA5C3);
    checkOne("wait_modo", 32'(modo), 32'd2);
    checkOne("wait_led", 32'(aguardando), 32'd1);
    checkOne("wait_en", 32'(cpu_en), 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 16'hA5C3);
    checkOne("confirm_ack", 32'(in_ack), 32'd1);
    checkOne("confirm_data", 32'(in_data), 32'hA5C3);
    checkOne("confirm_ret", 32'(modo), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000);
    checkOne("ack_single", 32'(in_ack), 32'd0);

    // WAIT_IN from STEP, modo toggles return mode, then confirm
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, 16'h1234);
    applyStimulus(0, 1, 0, 1, 0, 16'h1234);
    applyStimulus(1, 0, 0, 1, 0, 16'h1234);
    checkOne("wait_step_ignored", 32'(cpu_en), 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 16'h1234);
    checkOne("toggled_ret", 32'(modo), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 16'h1234);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // in_req dropped before confirm
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 16'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 16'hFFFF);
    checkOne("drop_modo", 32'(modo), 32'd0);
    checkOne("drop_ack", 32'(in_ack), 32'd0);
    checkOne("drop_data", 32'(in_data), 32'h1234);

    // Simultaneous step and modo edges
    applyStimulus(1, 1, 0, 0, 0, '0);
    checkOne("dual_modo", 32'(modo), 32'd1);
    checkOne("dual_en", 32'(cpu_en), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Random traffic against the model
    reqLvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) reqLvl = ~reqLvl;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 3) == 0, reqLvl, 1'b0, DW'($urandom));
    end

    // halt wins over in_req and locks the sequencer
    applyStimulus(0, 0, 0, 1, 1, '0);
    checkOne("halt_modo", 32'(modo), 32'd3);
    for (int i = 0; i < 30; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, DW'($urandom));
    checkOne("halt_locked", 32'(modo), 32'd3);

    // Reset exits HALTED; then reset asserted mid WAIT_IN with a confirm pending
    reset = 1'b0;
    #2;
    modelReset();
    checkOutput();
    btn_step = 1'b0; btn_modo = 1'b0; btn_confirma = 1'b0; in_req = 1'b0; halt = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) applyStimulus(0, 0, 0, 1, 0, 16'hBEEF);
    checkOne("pre_reset_wait", 32'(modo), 32'd2);
    btn_confirma = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      checkOne("rst_in_ack", 32'(in_ack), 32'd0);
      checkOne("rst_in_data", 32'(in_data), 32'd0);
      checkOne("rst_modo", 32'(modo), 32'd0);
      checkOne("rst_led", 32'(aguardando), 32'd0);
    end
    in_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 16'hBEEF);
    checkOne("post_reset_no_ack", 32'(in_ack), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
